// File: rtl/pokey_audio_channel_pkg.sv
// Shared POKEY constants: AUDC field positions, AUDCTL bit positions, widths.
package pokey_audio_channel_pkg;

    localparam int unsigned AUDF_W = 8;
    localparam int unsigned AUDC_W = 8;
    localparam int unsigned VOL_W  = 4;

    // AUDC field bit indices
    localparam int unsigned DIST_NO_POLY5 = 7;
    localparam int unsigned DIST_POLY4    = 6;
    localparam int unsigned DIST_PURE     = 5;
    localparam int unsigned VOL_ONLY      = 4;
    localparam int unsigned VOL_MSB       = 3;

    // AUDCTL bit indices used by the POKEY top
    localparam int unsigned AUDCTL_POLY9    = 7;
    localparam int unsigned AUDCTL_CH1_FAST = 6;
    localparam int unsigned AUDCTL_CH3_FAST = 5;
    localparam int unsigned AUDCTL_JOIN_12  = 4;
    localparam int unsigned AUDCTL_JOIN_34  = 3;
    localparam int unsigned AUDCTL_HP_13    = 2;
    localparam int unsigned AUDCTL_HP_24    = 1;
    localparam int unsigned AUDCTL_CLK_15K  = 0;

endpackage

// File: rtl/pokey_audio_divider.sv
// 8-bit reloadable down-counter; pulses underflow for one ce cycle after expiry.
module pokey_audio_divider
    import pokey_audio_channel_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              enable,
    input  logic              reload,
    input  logic [AUDF_W-1:0] audf,
    output logic              underflow,
    output logic              expire_c
);

    logic [AUDF_W-1:0] cnt;
    logic              underflow_r;

    // Expiry: an enable tick at zero count, unless a reload overrides it
    assign expire_c = enable & ~reload & (cnt == '0);

    // Counter and underflow register; reload wins over enable
    always_ff @(posedge clk) begin
        if (ce) begin
            if (!reset_n) begin
                cnt         <= '0;
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= expire_c;
                if (reload) begin
                    cnt <= audf;
                end else if (enable) begin
                    cnt <= (cnt == '0) ? audf : cnt - AUDF_W'(1);
                end
            end
        end
    end

    assign underflow = underflow_r;

endmodule

// File: rtl/pokey_audio_channel.sv
// One POKEY audio channel: divider, poly distortion, optional high-pass, volume.
module pokey_audio_channel
    import pokey_audio_channel_pkg::*;
#(
    parameter bit HP_ENABLE = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              enable,
    input  logic [AUDF_W-1:0] audf,
    input  logic [AUDC_W-1:0] audc,
    input  logic              reload,
    input  logic              poly4_bit,
    input  logic              poly5_bit,
    input  logic              poly17_bit,
    input  logic              hp_en,
    input  logic              hp_clk,
    output logic              underflow,
    output logic [VOL_W-1:0]  channel_out
);

    logic             expire_c;
    logic             tone_ff;
    logic             hp_ff;
    logic             filt;
    logic             gate;
    logic             tone_next;
    logic [VOL_W-1:0] vol;

    pokey_audio_divider u_divider (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .enable    (enable),
        .reload    (reload),
        .audf      (audf),
        .underflow (underflow),
        .expire_c  (expire_c)
    );

    // Distortion selection for the tone flip-flop
    always_comb begin
        gate      = audc[DIST_NO_POLY5] | poly5_bit;
        tone_next = tone_ff;
        if (audc[DIST_PURE]) begin
            tone_next = ~tone_ff;
        end else if (audc[DIST_POLY4]) begin
            tone_next = poly4_bit;
        end else begin
            tone_next = poly17_bit;
        end
    end

    // Tone flip-flop updates only on a gated expiry
    always_ff @(posedge clk) begin
        if (ce) begin
            if (!reset_n) begin
                tone_ff <= 1'b0;
            end else if (expire_c && gate) begin
                tone_ff <= tone_next;
            end
        end
    end

    generate
        if (HP_ENABLE) begin : g_hp
            // High-pass flip-flop samples the pre-update tone on partner underflow
            always_ff @(posedge clk) begin
                if (ce) begin
                    if (!reset_n) begin
                        hp_ff <= 1'b0;
                    end else if (hp_clk) begin
                        hp_ff <= tone_ff;
                    end
                end
            end
            assign filt = hp_en ? (tone_ff ^ hp_ff) : tone_ff;
        end else begin : g_no_hp
            assign hp_ff = 1'b0;
            assign filt  = tone_ff;
        end
    endgenerate

    // Volume stage; volume-only mode bypasses the waveform
    assign vol         = audc[VOL_MSB:0];
    assign channel_out = (audc[VOL_ONLY] || filt) ? vol : '0;

endmodule
